// File: rtl/exec_pkg.sv
// Shared types for the exec_unit execute stage: ALU opcodes, writeback
// result selects and the wide-immediate lane width.
package exec_pkg;

  localparam int LANE_W = 16;

  typedef enum logic [2:0] {
    ALU_PASSB = 3'b000,
    ALU_ADD   = 3'b010,
    ALU_SUB   = 3'b011,
    ALU_AND   = 3'b100,
    ALU_OR    = 3'b101,
    ALU_XOR   = 3'b110
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MOVZ = 2'b01,
    RES_MOVK = 2'b10,
    RES_ZERO = 2'b11
  } res_sel_e;

endpackage

// File: rtl/exec_alu.sv
// Combinational integer ALU: pass-B, add, subtract, AND, OR, XOR with
// N/Z/V/C status. V and C are only driven for add/subtract.
module exec_alu #(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        alu_op,
  output logic [DATA_W-1:0] r,
  output logic              n,
  output logic              z,
  output logic              v,
  output logic              c
);
  import exec_pkg::*;

  logic              is_sub;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;

  always_comb begin
    is_sub = (alu_op == ALU_SUB);
    // Subtract shares the adder as A + ~B + 1, so C is NOT borrow.
    b_eff  = is_sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};
    r      = '0;
    v      = 1'b0;
    c      = 1'b0;
    case (alu_op)
      ALU_PASSB: r = b;
      ALU_ADD, ALU_SUB: begin
        r = sum[DATA_W-1:0];
        c = sum[DATA_W];
        v = (a[DATA_W-1] == b_eff[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      default: r = '0;
    endcase
    n = r[DATA_W-1];
    z = ~|r;
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: ALU, MOVZ/MOVK wide-immediate generators, writeback mux and
// NZVC flag register. Define EXEC_OUT_REG_EN to register the result output.
module exec_unit #(
  parameter int DATA_W = 64,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] k_src,
  input  logic [IMM_W-1:0]  imm16,
  input  logic [1:0]        hw,
  input  logic [2:0]        alu_op,
  input  logic [1:0]        res_sel,
  input  logic              set_flag,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              negative,
  output logic              overflow,
  output logic              carry_out,
  output logic              zf,
  output logic              nf,
  output logic              of,
  output logic              cf
);
  import exec_pkg::*;

  localparam int NLANES = DATA_W / LANE_W;

  logic [DATA_W-1:0] alu_r;
  logic [DATA_W-1:0] movz_val;
  logic [DATA_W-1:0] movk_val;
  logic [DATA_W-1:0] result_d;
  logic [3:0]        flags_d;
  logic [3:0]        flags_q;
  int unsigned       hw_lane;

  exec_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (a),
    .b      (b),
    .alu_op (alu_op),
    .r      (alu_r),
    .n      (negative),
    .z      (zero),
    .v      (overflow),
    .c      (carry_out)
  );

  // Narrower datapaths have fewer lanes, so hw wraps onto the ones that exist.
  assign hw_lane = 32'(hw) % 32'(NLANES);

  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    assign movz_val[gi*LANE_W +: LANE_W] = (hw_lane == gi) ? imm16 : '0;
    assign movk_val[gi*LANE_W +: LANE_W] = (hw_lane == gi) ? imm16 : k_src[gi*LANE_W +: LANE_W];
  end

  always_comb begin
    result_d = '0;
    case (res_sel)
      RES_ALU:  result_d = alu_r;
      RES_MOVZ: result_d = movz_val;
      RES_MOVK: result_d = movk_val;
      default:  result_d = '0;
    endcase
  end

  always_comb begin
    flags_d = set_flag ? {zero, negative, overflow, carry_out} : flags_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign {zf, nf, of, cf} = flags_q;

`ifdef EXEC_OUT_REG_EN
  logic [DATA_W-1:0] result_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) result_q <= '0;
    else        result_q <= result_d;
  end

  assign result = result_q;
`else
  assign result = result_d;
`endif

endmodule

// File: tb/tb_exec_unit.sv
// Randomized self-checking bench for exec_unit against an arithmetic reference
// model, plus literal directed cases that pin the model itself.
module tb_exec_unit;
  import exec_pkg::*;

  typedef struct packed {
    logic [63:0] r;
    logic        z;
    logic        n;
    logic        v;
    logic        c;
  } alu_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] a_i, b_i, k_i;
  logic [15:0] imm_i;
  logic [1:0]  hw_i;
  logic [2:0]  op_i;
  logic [1:0]  sel_i;
  logic        sf_i;
  logic [63:0] result;
  logic        zero, negative, overflow, carry_out;
  logic        zf, nf, of, cf;

  int          tests = 0;
  int          fails = 0;
  bit          cmp_en = 1'b0;
  logic [3:0]  m_flags;     // {z,n,v,c}
  logic [63:0] m_res_prev;
  alu_t        e_alu;
  logic [63:0] e_res;

  always #5 clk = ~clk;

  exec_unit #(.DATA_W(64), .IMM_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a_i),
    .b         (b_i),
    .k_src     (k_i),
    .imm16     (imm_i),
    .hw        (hw_i),
    .alu_op    (op_i),
    .res_sel   (sel_i),
    .set_flag  (sf_i),
    .result    (result),
    .zero      (zero),
    .negative  (negative),
    .overflow  (overflow),
    .carry_out (carry_out),
    .zf        (zf),
    .nf        (nf),
    .of        (of),
    .cf        (cf)
  );

  function automatic alu_t model_alu(input logic [63:0] x, input logic [63:0] y, input logic [2:0] op);
    alu_t o;
    o = '0;
    case (op)
      3'b000: o.r = y;
      3'b010: begin
        o.r = x + y;
        o.c = (o.r < x);
        o.v = (x[63] == y[63]) && (o.r[63] != x[63]);
      end
      3'b011: begin
        o.r = x - y;
        o.c = (x >= y);
        o.v = (x[63] != y[63]) && (o.r[63] != x[63]);
      end
      3'b100: o.r = x & y;
      3'b101: o.r = x | y;
      3'b110: o.r = x ^ y;
      default: o.r = 64'd0;
    endcase
    o.z = (o.r == 64'd0);
    o.n = o.r[63];
    return o;
  endfunction

  function automatic logic [63:0] model_res(input logic [63:0] r, input logic [63:0] k,
                                            input logic [15:0] imm, input logic [1:0] h,
                                            input logic [1:0] sel);
    int          sh;
    logic [63:0] mask;
    logic [63:0] placed;
    sh     = 16 * int'(h);
    mask   = 64'h0000_0000_0000_FFFF << sh;
    placed = {48'd0, imm} << sh;
    case (sel)
      2'd0:    return r;
      2'd1:    return placed;
      2'd2:    return (k & ~mask) | placed;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_0000_0000;
      4:       return 64'($urandom_range(0, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [63:0] ta, input logic [63:0] tb, input logic [63:0] tk,
                       input logic [15:0] timm, input logic [1:0] thw, input logic [2:0] top,
                       input logic [1:0] tsel, input logic tsf);
    a_i = ta; b_i = tb; k_i = tk; imm_i = timm;
    hw_i = thw; op_i = top; sel_i = tsel; sf_i = tsf;
  endtask

  // Advance one clock edge and update the architectural model for that edge.
  task automatic step();
    alu_t m;
    @(posedge clk);
    m = model_alu(a_i, b_i, op_i);
    if (reset) begin
      if (sf_i) m_flags = {m.z, m.n, m.v, m.c};
      m_res_prev = model_res(m.r, k_i, imm_i, hw_i, sel_i);
    end
    $display("[TB] t=%0t rst_n=%0b op=%0d sel=%0d hw=%0d sf=%0b a=%h b=%h result=%h znvc=%b%b%b%b",
             $time, reset, op_i, sel_i, hw_i, sf_i, a_i, b_i, result, zero, negative, overflow, carry_out);
    #1;
  endtask

  task automatic lit(input string nm, input logic [63:0] exp_res, input logic [3:0] exp_znvc);
    alu_t        m;
    logic [63:0] mr;
    m  = model_alu(a_i, b_i, op_i);
    mr = model_res(m.r, k_i, imm_i, hw_i, sel_i);
    chk({nm, "_model_res"}, mr, exp_res);
    chk({nm, "_model_znvc"}, {60'd0, m.z, m.n, m.v, m.c}, {60'd0, exp_znvc});
`ifndef EXEC_OUT_REG_EN
    chk({nm, "_dut_res"}, result, exp_res);
`endif
    chk({nm, "_dut_znvc"}, {60'd0, zero, negative, overflow, carry_out}, {60'd0, exp_znvc});
  endtask

  task automatic async_reset_pulse();
    #2;
    reset = 1'b0;
    m_flags = 4'b0000;
    m_res_prev = 64'd0;
    #1;
    chk("async_reset_flags", {60'd0, zf, nf, of, cf}, 64'd0);
    step();
    reset = 1'b1;
  endtask

  // Single compare process: every cycle, mid-period, DUT against model.
  always @(negedge clk) begin
    if (cmp_en) begin
      e_alu = model_alu(a_i, b_i, op_i);
`ifdef EXEC_OUT_REG_EN
      e_res = m_res_prev;
`else
      e_res = model_res(e_alu.r, k_i, imm_i, hw_i, sel_i);
`endif
      chk("result", result, e_res);
      chk("zero", {63'd0, zero}, {63'd0, e_alu.z});
      chk("negative", {63'd0, negative}, {63'd0, e_alu.n});
      chk("overflow", {63'd0, overflow}, {63'd0, e_alu.v});
      chk("carry_out", {63'd0, carry_out}, {63'd0, e_alu.c});
      chk("flags_zncv", {60'd0, zf, nf, of, cf}, {60'd0, m_flags});
    end
  end

  initial begin
    reset = 1'b0;
    drive(64'd0, 64'd0, 64'd0, 16'd0, 2'd0, 3'd0, 2'd0, 1'b0);
    m_flags = 4'b0000;
    m_res_prev = 64'd0;
    #2;
    chk("reset_flags", {60'd0, zf, nf, of, cf}, 64'd0);
    cmp_en = 1'b1;
    step();
    reset = 1'b1;

    drive(64'd5, 64'd3, 64'd0, 16'd0, 2'd0, ALU_ADD, RES_ALU, 1'b1); #1;
    lit("add_5_3", 64'd8, 4'b0000);
    step();
    chk("add_5_3_flags", {60'd0, zf, nf, of, cf}, 64'd0);

    drive(64'd3, 64'd5, 64'd0, 16'd0, 2'd0, ALU_SUB, RES_ALU, 1'b0); #1;
    lit("sub_3_5", 64'hFFFF_FFFF_FFFF_FFFE, 4'b0100);
    step();
    drive(64'd7, 64'd7, 64'd0, 16'd0, 2'd0, ALU_SUB, RES_ALU, 1'b0); #1;
    lit("sub_7_7", 64'd0, 4'b1001);
    step();
    drive(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 16'd0, 2'd0, ALU_ADD, RES_ALU, 1'b0); #1;
    lit("add_ovf", 64'h8000_0000_0000_0000, 4'b0110);
    step();
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 16'd0, 2'd0, ALU_ADD, RES_ALU, 1'b0); #1;
    lit("add_carry", 64'd0, 4'b1001);
    step();
    drive(64'd9, 64'd0, 64'd0, 16'hBEEF, 2'd2, ALU_PASSB, RES_MOVZ, 1'b0); #1;
    lit("movz", 64'h0000_BEEF_0000_0000, 4'b1000);
    step();
    drive(64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 16'h1234, 2'd1, ALU_PASSB, RES_MOVK, 1'b0); #1;
    lit("movk", 64'hFFFF_FFFF_1234_FFFF, 4'b1000);
    step();
    drive(64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000, 64'd0, 16'd0, 2'd0, 3'b111, RES_ALU, 1'b0); #1;
    lit("op111", 64'd0, 4'b1000);
    step();

    // Load N=1 Z=0 V=0 C=1, then hold across three edges with set_flag low.
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 16'd0, 2'd0, ALU_SUB, RES_ALU, 1'b1); #1;
    lit("load_nc", 64'hFFFF_FFFF_FFFF_FFFE, 4'b0101);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(rnd64(), rnd64(), rnd64(), 16'($urandom), 2'($urandom), 3'($urandom), 2'($urandom), 1'b0);
      step();
      chk("flags_hold_nzvc", {60'd0, nf, zf, of, cf}, {60'd0, 4'b1001});
    end
    drive(64'd0, 64'd0, 64'd0, 16'd0, 2'd0, ALU_ADD, RES_ALU, 1'b1);
    async_reset_pulse();

    for (int i = 0; i < 300; i++) begin
      logic [63:0] ra;
      ra = rnd64();
      drive(ra, ($urandom_range(0, 7) == 0) ? ra : rnd64(), rnd64(), 16'($urandom),
            2'($urandom), 3'($urandom), 2'($urandom), 1'($urandom));
      if ($urandom_range(0, 49) == 0) async_reset_pulse();
      else step();
    end

    @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
